// File: rtl/sad_array_16_pkg.sv
// sad_array_16_pkg: shared widths, lane count and the SAD width rule.
// Provides default pixel/element widths, block size, the fixed lane count,
// and the width check used by the SAD array, min tree and motion-vector stages.
package sad_array_16_pkg;
  localparam int LANES = 16;
  localparam int DEF_PIXEL_BIT_DEPTH = 8;
  localparam int DEF_ELEMENT_BIT_DEPTH = 14;
  localparam int DEF_BLOCK_PIXELS = 64;
  // An element must hold BLOCK_PIXELS worst-case abs-diffs without wrapping.
  function automatic bit sad_width_ok(int p, int b, int e);
    return e >= p + $clog2(b);
  endfunction
  localparam bit SAD_WIDTH_OK =
    sad_width_ok(DEF_PIXEL_BIT_DEPTH, DEF_BLOCK_PIXELS, DEF_ELEMENT_BIT_DEPTH);
endpackage

// File: rtl/sad_array_16_abs_diff_acc.sv
// sad_array_16_abs_diff_acc: one SAD lane, |cur - ref_pixel| accumulator.
// Ports: clk, rst (async, active-high), cur, ref_pixel, en (beat accepted),
// clear_on_en (this beat closes the block), next_sum (acc + this beat's abs-diff).
module sad_array_16_abs_diff_acc #(
  parameter int P = 8,
  parameter int E = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [P-1:0] cur,
  input  logic [P-1:0] ref_pixel,
  input  logic         en,
  input  logic         clear_on_en,
  output logic [E-1:0] next_sum
);
  logic [E-1:0] acc;
  logic [P-1:0] diff;
  assign diff = cur >= ref_pixel ? cur - ref_pixel : ref_pixel - cur;
  assign next_sum = acc + E'(diff);
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else if (en) acc <= clear_on_en ? '0 : next_sum;
endmodule

// File: rtl/sad_array_16.sv
// sad_array_16: 16-lane SAD accumulator with a held output register.
// Ports: clk, rst (async, active-high); in_valid/in_ready, cur_pixel,
// ref_pixels (lane k at [k*P +: P]); out_valid/out_ready, sad_array
// (lane k at [k*E +: E], min-tree packing).
module sad_array_16
  import sad_array_16_pkg::*;
#(
  parameter int PIXEL_BIT_DEPTH = DEF_PIXEL_BIT_DEPTH,
  parameter int BLOCK_PIXELS = DEF_BLOCK_PIXELS,
  parameter int ELEMENT_BIT_DEPTH = DEF_ELEMENT_BIT_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PIXEL_BIT_DEPTH-1:0]     cur_pixel,
  input  logic [PIXEL_BIT_DEPTH*16-1:0]  ref_pixels,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ELEMENT_BIT_DEPTH*16-1:0] sad_array
);
  localparam int P = PIXEL_BIT_DEPTH;
  localparam int E = ELEMENT_BIT_DEPTH;
  localparam int CW = $clog2(BLOCK_PIXELS);
  if (!sad_width_ok(P, BLOCK_PIXELS, E) || BLOCK_PIXELS < 2 ||
      (BLOCK_PIXELS & (BLOCK_PIXELS - 1)) != 0) begin : g_bad_params
    $error("sad_array_16: illegal PIXEL/ELEMENT/BLOCK parameters");
  end
  logic [CW-1:0] beat_cnt;
  logic [E*LANES-1:0] next_sums;
  logic last, accept;
  assign last = beat_cnt == CW'(BLOCK_PIXELS - 1);
  // Only the closing beat can stall: it needs the output register free.
  assign in_ready = !(last && out_valid && !out_ready);
  assign accept = in_valid && in_ready;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sad_array_16_abs_diff_acc #(.P(P), .E(E)) u_lane (
      .clk(clk),
      .rst(rst),
      .cur(cur_pixel),
      .ref_pixel(ref_pixels[k*P +: P]),
      .en(accept),
      .clear_on_en(last),
      .next_sum(next_sums[k*E +: E])
    );
  end
  // beat_cnt wraps naturally at BLOCK_PIXELS (power of two).
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      beat_cnt <= '0;
      out_valid <= 1'b0;
      sad_array <= '0;
    end else begin
      if (accept) beat_cnt <= beat_cnt + 1'b1;
      if (accept && last) begin
        out_valid <= 1'b1;
        sad_array <= next_sums;
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule

// File: doc/sad_array_16.md
# sad_array_16

Sixteen-lane sum-of-absolute-differences accumulator for the motion-estimation datapath. Each accepted beat carries one current-block pixel and the co-located pixels of 16 candidate reference positions. The block accumulates |cur − ref_k| per lane over one block. It then presents the 16 SADs as a packed array, which feeds the 16-input minimum tree directly downstream. Completed results are held in an output register, so the next block can accumulate while the downstream stage stalls.

## Interface
- PIXEL_BIT_DEPTH, 8: bits per pixel.
- BLOCK_PIXELS, 64: beats per block (8x8). Must be a power of two, at least 2.
- ELEMENT_BIT_DEPTH, 14: bits per SAD lane. Required: ELEMENT_BIT_DEPTH ≥ PIXEL_BIT_DEPTH + log2(BLOCK_PIXELS). Elaboration error otherwise.

Ports:
- clk  in  1  single clock; all state is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- cur_pixel  in  PIXEL_BIT_DEPTH  current-block pixel.
- ref_pixels  in  PIXEL_BIT_DEPTH*16  candidate k at [(k+1)*P−1 : k*P].
- out_valid  out  1  sad_array holds a completed block.
- out_ready  in  1  downstream consumes when out_valid && out_ready.
- sad_array  out  ELEMENT_BIT_DEPTH*16  lane k at [(k+1)*E−1 : k*E], matching the min-tree input packing.

## Operation
- Per lane, abs-diff is unsigned: cur ≥ ref ? cur − ref : ref − cur, zero-extended to E bits. It is added to the lane accumulator without saturation; the width rule guarantees no overflow.
- beat_cnt counts accepted beats, 0..BLOCK_PIXELS−1, and wraps to 0 on the last beat.
- Last beat (accept while beat_cnt == BLOCK_PIXELS−1):
  - sad_array ← acc + abs-diff of this beat, all 16 lanes.
  - out_valid ← 1.
  - All accumulators ← 0 in the same cycle.
- Non-last accepted beat: acc ← acc + abs-diff.
- Output register holds its value and out_valid stays high until consumed.
- Output states:
  - EMPTY (out_valid=0) → FULL on last beat.
  - FULL → EMPTY on consume with no simultaneous last beat.
  - FULL → FULL on consume and last beat in the same cycle; the new result is loaded.
- in_ready = !(beat_cnt == BLOCK_PIXELS−1 && out_valid && !out_ready).
  - Only the last beat of a block can stall. Beats 0..BLOCK_PIXELS−2 are always accepted.
  - in_ready depends combinationally on out_ready; no other comb path from input to output.
- in_valid low: no state change.
- Reset (any time, including mid-block) clears:
  - beat_cnt=0 and all accumulators 0.
  - sad_array=0 and out_valid=0.
  - The partial block is discarded. in_ready reads 1 while and after rst.

## Timing
- Latency: out_valid and sad_array are updated on the clock edge that accepts the last beat. They are visible the following cycle.
- Throughput: one beat per cycle sustained, and one block per BLOCK_PIXELS cycles when out_ready is held high. No bubble between blocks.
- Downstream min tree is combinational; its result is valid whenever out_valid is high.
- Reset values: in_ready=1, out_valid=0, sad_array=0.

## Structure
- Shared include holds:
  - default PIXEL_BIT_DEPTH, ELEMENT_BIT_DEPTH, BLOCK_PIXELS;
  - the lane count 16;
  - the width-check localparam, also used by the min tree and later motion-vector stages.
- Sub-module ABS_DIFF_ACC, instantiated 16 times in a generate loop. Per lane it has:
  - inputs: cur, ref, en, clear_on_en;
  - output: the next-sum value.
- The top level owns beat_cnt, the output register and the ready logic.

## Test plan
- Block with cur=200 and ref_k=200−k for all 64 beats, out_ready=1 → one out_valid pulse after the 64th accept; lane k = 64·k (lane 15 = 960).
- cur=255 and all ref=0 for 64 beats → every lane = 16320, no wrap; alternating cur/ref swaps give the same result.
- Two back-to-back blocks with out_ready=0 throughout:
  - first result is held; in_ready drops only at beat 63 of block 2;
  - raising out_ready then accepts the stalled beat in the same cycle, and the second result is loaded next cycle.
- in_valid toggled randomly 50% over one block of known data → SADs identical to the gap-free run.
- Assert rst after 30 beats, then send a full block of cur=10 and ref_k=k → lane k = 64·|10−k|; no residue from the aborted block.
- Consume and last beat in the same cycle → out_valid stays 1, and sad_array changes to the new block's values without a gap.
